// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI responder: controller state
//               encoding, byte width, default fill byte and SPI mode
//               constants expressed as {CPOL,CPHA}.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int unsigned BYTE_W = 8;

  // Byte sent when the transmit holding buffer is empty at a load point.
  localparam logic [BYTE_W-1:0] FILL_BYTE_DEFAULT = 8'hFF;

  // SPI modes as {CPOL,CPHA}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT_DESEL = 2'd0,
    ST_IDLE       = 2'd1,
    ST_ACTIVE     = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Brings the asynchronous SPI pins SCK, CE and MOSI into the
//               clk domain through SYNC_STAGES flops each, and produces
//               single-cycle SCK rise/fall and CE fall/rise strobes.
// Ports       : clk, rst      - system clock, synchronous active-high reset
//               sck_i/ce_i/mosi_i - raw pins
//               ce_o, mosi_o  - synchronised CE and MOSI levels
//               sck_rise_o / sck_fall_o - synchronised SCK edge strobes
//               ce_fall_o / ce_rise_o   - synchronised CE edge strobes
// Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic ce_i,
  input  logic mosi_i,
  output logic ce_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic ce_fall_o,
  output logic ce_rise_o
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ce_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_prev_q;
  logic                   ce_prev_q;

  logic sck_sync;
  logic ce_sync;

  assign sck_sync = sck_q[SYNC_STAGES-1];
  assign ce_sync  = ce_q[SYNC_STAGES-1];

  // The CE chain resets to "selected" (0): if reset lands in the middle of a
  // frame the controller must keep waiting until the real pin is seen high,
  // rather than trusting a reset value that claims deselection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q      <= '0;
      ce_q       <= '0;
      mosi_q     <= '1;
      sck_prev_q <= 1'b0;
      ce_prev_q  <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      ce_q       <= {ce_q[SYNC_STAGES-2:0], ce_i};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q <= sck_sync;
      ce_prev_q  <= ce_sync;
    end
  end

  assign ce_o       = ce_sync;
  assign mosi_o     = mosi_q[SYNC_STAGES-1];
  assign sck_rise_o =  sck_sync & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync &  sck_prev_q;
  assign ce_fall_o  = ~ce_sync  &  ce_prev_q;
  assign ce_rise_o  =  ce_sync  & ~ce_prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_responder
// Description : SPI slave for all four CPOL/CPHA modes, MSB first. Pins are
//               oversampled in the clk domain. Received bytes are presented
//               on rxData with a one-cycle rxValid strobe; bytes to send are
//               taken from a one-entry holding buffer (txData/txValid/
//               txReady) and FILL_BYTE is sent when that buffer is empty.
// Ports       : clk, rst            - system clock, sync active-high reset
//               SCK, CE, MOSI, MISO - SPI pins (CE active low)
//               CPOL, CPHA          - mode select, static while CE low
//               txData/txValid/txReady - transmit holding buffer handshake
//               rxData/rxValid      - received byte and strobe
//               txUnderrun          - FILL_BYTE substituted at a load point
//               frameErr            - CE rose mid-byte
//               busy                - frame in progress
//               misoOE              - MISO pad enable (only with macro)
// Build option: define SPI_RESPONDER_MISO_OE_EN to add the misoOE output.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              CE,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [BYTE_W-1:0] txData,
  input  logic              txValid,
  output logic              txReady,
  output logic [BYTE_W-1:0] rxData,
  output logic              rxValid,
  output logic              txUnderrun,
  output logic              frameErr,
  output logic              busy
`ifdef SPI_RESPONDER_MISO_OE_EN
  ,
  output logic              misoOE
`endif
);

  // --------------------------------------------------------------------------
  // Pin conditioning
  // --------------------------------------------------------------------------
  logic ce_sync;
  logic mosi_sync;
  logic sck_rise;
  logic sck_fall;
  logic ce_fall;
  logic ce_rise;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (SCK),
    .ce_i       (CE),
    .mosi_i     (MOSI),
    .ce_o       (ce_sync),
    .mosi_o     (mosi_sync),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .ce_fall_o  (ce_fall),
    .ce_rise_o  (ce_rise)
  );

  // Edges of the normalised clock sckN = sck ^ CPOL.
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;

  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [2:0]        bit_cnt_q,   bit_cnt_d;
  logic [BYTE_W-1:0] rx_shift_q,  rx_shift_d;
  logic [BYTE_W-1:0] rx_data_q,   rx_data_d;
  logic              rx_valid_q,  rx_valid_d;
  logic [BYTE_W-1:0] tx_buf_q,    tx_buf_d;
  logic              tx_full_q,   tx_full_d;
  logic [BYTE_W-1:0] tx_shift_q,  tx_shift_d;
  logic              miso_q,      miso_d;
  logic              underrun_q,  underrun_d;
  logic              frame_err_q, frame_err_d;

  logic              do_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WAIT_DESEL;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= '1;
      miso_q      <= 1'b1;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    do_load     = 1'b0;

    case (state_q)
      ST_WAIT_DESEL: begin
        miso_d    = 1'b1;
        bit_cnt_d = 3'd0;
        if (ce_sync) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        miso_d    = 1'b1;
        bit_cnt_d = 3'd0;
        if (ce_fall) begin
          state_d = ST_ACTIVE;
          // With CPHA=0 the first bit must already be on MISO before the
          // first (sampling) clock edge arrives.
          do_load = ~CPHA;
        end
      end

      ST_ACTIVE: begin
        if (ce_rise) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b1;
          bit_cnt_d   = 3'd0;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_sync};
          // 3-bit counter wraps to 0 on the 8th sample.
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[BYTE_W-2:0], mosi_sync};
            rx_valid_d = 1'b1;
          end
        end else if (shift_edge) begin
          if (bit_cnt_q == 3'd0) begin
            do_load = 1'b1;
          end else begin
            // MISO always shows the MSB of the register after shifting, so
            // the bit presented next is the one just below the current MSB.
            miso_d     = tx_shift_q[BYTE_W-2];
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = ST_WAIT_DESEL;
        miso_d  = 1'b1;
      end
    endcase

    if (do_load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        miso_d     = tx_buf_q[BYTE_W-1];
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = FILL_BYTE;
        miso_d     = FILL_BYTE[BYTE_W-1];
        underrun_d = 1'b1;
      end
    end

    // Buffer accepts only while empty, so this never collides with a load
    // that drains a full buffer. An empty-buffer load in the same cycle
    // still sends FILL_BYTE; the accepted byte waits for the next load.
    if (txValid && !tx_full_q) begin
      tx_buf_d  = txData;
      tx_full_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign MISO       = miso_q;
  assign txReady    = ~tx_full_q;
  assign rxData     = rx_data_q;
  assign rxValid    = rx_valid_q;
  assign txUnderrun = underrun_q;
  assign frameErr   = frame_err_q;
  assign busy       = (state_q == ST_ACTIVE);

`ifdef SPI_RESPONDER_MISO_OE_EN
  assign misoOE = (state_q == ST_ACTIVE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_responder
// Description : Self-checking bench for spi_responder. An SPI initiator task
//               drives directed and random frames; a frame-level model
//               predicts received bytes, MISO bytes, underruns and framing
//               errors from the number of load points in each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

  localparam int         S    = 2;
  localparam int         H    = 8;        // SCK half period in clk cycles
  localparam logic [7:0] FILL = 8'hFF;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       SCK     = 1'b0;
  logic       CE      = 1'b1;
  logic       MOSI    = 1'b1;
  logic       CPOL    = 1'b0;
  logic       CPHA    = 1'b0;
  logic [7:0] txData  = 8'h00;
  logic       txValid = 1'b0;
  logic       MISO;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       txUnderrun;
  logic       frameErr;
  logic       busy;
`ifdef SPI_RESPONDER_MISO_OE_EN
  logic       misoOE;
`endif

  spi_responder #(
    .SYNC_STAGES (S),
    .FILL_BYTE   (FILL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SCK        (SCK),
    .CE         (CE),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .CPOL       (CPOL),
    .CPHA       (CPHA),
    .txData     (txData),
    .txValid    (txValid),
    .txReady    (txReady),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .txUnderrun (txUnderrun),
    .frameErr   (frameErr),
    .busy       (busy)
`ifdef SPI_RESPONDER_MISO_OE_EN
    ,
    .misoOE     (misoOE)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse monitor.
  int         rx_cnt   = 0;
  int         und_cnt  = 0;
  int         ferr_cnt = 0;
  logic [7:0] rx_log [0:255];

  always @(negedge clk) begin
    if (rxValid) begin
      rx_log[rx_cnt[7:0]] <= rxData;
      rx_cnt <= rx_cnt + 1;
    end
    if (txUnderrun) und_cnt  <= und_cnt + 1;
    if (frameErr)   ferr_cnt <= ferr_cnt + 1;
  end

  // Transmit feeder: presents queued bytes whenever the buffer takes them.
  logic [7:0] feed_mem [0:255];
  int         feed_wr = 0;
  int         feed_rd = 0;
  logic       hs_seen = 1'b0;

  always @(posedge clk) hs_seen <= txValid && txReady;

  initial begin
    forever begin
      @(negedge clk);
      if (hs_seen && feed_rd < feed_wr) feed_rd = feed_rd + 1;
      if (feed_rd < feed_wr) begin
        txValid = 1'b1;
        txData  = feed_mem[feed_rd[7:0]];
      end else begin
        txValid = 1'b0;
      end
    end
  end

  // Model of bytes the responder owns (holding buffer plus pending feed).
  logic [7:0] mq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    feed_mem[feed_wr[7:0]] = b;
    feed_wr = feed_wr + 1;
    mq.push_back(b);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " MISO"},       32'(MISO),       32'd1);
    check({tag, " txReady"},    32'(txReady),    32'd1);
    check({tag, " rxData"},     32'(rxData),     32'h00);
    check({tag, " rxValid"},    32'(rxValid),    32'd0);
    check({tag, " txUnderrun"}, 32'(txUnderrun), 32'd0);
    check({tag, " frameErr"},   32'(frameErr),   32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
  endtask

  // One initiator frame of nbits bits taken MSB first from mw. If rst_bit is
  // non-negative, rst is pulsed just before that bit and the frame is only
  // checked for silence afterwards.
  task automatic run_frame(input string name, input logic [1:0] mode,
                           input logic [31:0] mw, input int nbits, input int rst_bit);
    logic [31:0] got;
    logic [31:0] sh;
    logic [7:0]  ld [$];
    int          rx0, und0, fe0;
    int          loads, exp_und, nfull;
    got = '0;
    CPOL = mode[1];
    CPHA = mode[0];
    SCK  = mode[1];
    repeat (8) @(negedge clk);
    #1;
    rx0 = rx_cnt; und0 = und_cnt; fe0 = ferr_cnt;
`ifdef SPI_RESPONDER_MISO_OE_EN
    check({name, " oe_idle"}, 32'(misoOE), 32'd0);
`endif
    @(negedge clk);
    CE = 1'b0;
    if (!mode[0]) MOSI = mw[31];
    repeat (S + 1) @(posedge clk);
    #1;
`ifdef SPI_RESPONDER_MISO_OE_EN
    check({name, " oe_rise"}, 32'(misoOE), 32'd1);
`endif
    @(negedge clk);
    repeat (H - S - 1) @(negedge clk);

    for (int i = 0; i < nbits; i++) begin
      if (mode[0]) begin
        SCK  = ~mode[1];
        sh   = mw << i;
        MOSI = sh[31];
        repeat (H) @(negedge clk);
      end
      if (i == rst_bit) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values({name, " midrst"});
        rx0 = rx_cnt; und0 = und_cnt; fe0 = ferr_cnt;
      end
      if (i == 1 && rst_bit < 0) check({name, " busy"}, 32'(busy), 32'd1);
      got[31-i] = MISO;
      SCK = mode[0] ? mode[1] : ~mode[1];
      repeat (H) @(negedge clk);
      if (!mode[0]) begin
        SCK  = mode[1];
        sh   = mw << (i + 1);
        MOSI = sh[31];
        repeat (H) @(negedge clk);
      end
    end
    CE = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
`ifdef SPI_RESPONDER_MISO_OE_EN
    check({name, " oe_fall"}, 32'(misoOE), 32'd0);
`endif
    repeat (10) @(negedge clk);
    #1;

    if (rst_bit >= 0) begin
      check({name, " silent_rx"},   32'(rx_cnt - rx0),    32'd0);
      check({name, " silent_und"},  32'(und_cnt - und0),  32'd0);
      check({name, " silent_ferr"}, 32'(ferr_cnt - fe0),  32'd0);
    end else begin
      // A byte is loaded at every point the responder must present a new
      // MSB: for CPHA=1 at the start of each begun byte; for CPHA=0 at CE
      // fall and after each completed byte.
      loads   = mode[0] ? (nbits + 7) / 8 : 1 + nbits / 8;
      nfull   = nbits / 8;
      exp_und = 0;
      for (int l = 0; l < loads; l++) begin
        if (mq.size() > 0) ld.push_back(mq.pop_front());
        else begin
          ld.push_back(FILL);
          exp_und++;
        end
      end
      check({name, " rx_count"}, 32'(rx_cnt - rx0), 32'(nfull));
      for (int b = 0; b < nfull; b++) begin
        check($sformatf("%s rx_byte%0d", name, b), 32'(rx_log[(rx0 + b) % 256]),
              32'(mw[31-8*b -: 8]));
        check($sformatf("%s miso_byte%0d", name, b), 32'(got[31-8*b -: 8]), 32'(ld[b]));
      end
      check({name, " underruns"}, 32'(und_cnt - und0), 32'(exp_und));
      check({name, " frame_err"}, 32'(ferr_cnt - fe0), ((nbits % 8) != 0) ? 32'd1 : 32'd0);
      check({name, " idle_busy"}, 32'(busy), 32'd0);
      check({name, " idle_miso"}, 32'(MISO), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [31:0] w;
    int          nb, np;

    repeat (4) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Mode 0, preloaded A5, master sends 3C.
    push_tx(8'hA5);
    repeat (6) @(negedge clk);
    #1;
    check("m0 txReady_full", 32'(txReady), 32'd0);
    run_frame("m0", 2'b00, 32'h3C00_0000, 8, -1);
    check("m0 txReady_after", 32'(txReady), 32'd1);

    // Mode 3, three back-to-back bytes with refills.
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    run_frame("m3", 2'b11, 32'h0312_3400, 24, -1);

    // Mode 1, buffer never filled.
    run_frame("m1", 2'b01, 32'h5AC3_0000, 16, -1);

    // Mode 2, aborted after five bits, then a clean byte.
    run_frame("m2err", 2'b10, 32'hA800_0000, 5, -1);
    run_frame("m2", 2'b10, 32'h8100_0000, 8, -1);

    // Reset during bit 3, then a normal frame.
    run_frame("rstmid", 2'b00, 32'h5A00_0000, 8, 3);
    push_tx(8'h96);
    run_frame("post_rst", 2'b00, 32'hC300_0000, 8, -1);

    // Random frames in random modes with random buffer supply.
    for (int r = 0; r < 6; r++) begin
      m  = 2'($urandom_range(0, 3));
      w  = $urandom;
      nb = 8 * $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) nb = nb - $urandom_range(1, 7);
      np = $urandom_range(0, 3);
      for (int k = 0; k < np; k++) push_tx(8'($urandom));
      run_frame($sformatf("rnd%0d", r), m, w, nb, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
